cic_dec_strobed: RTL and testbench

CIC_DEC_STROBED -- requirements
Module: cic_dec_strobed

---
 rtl/cic_dec_strobed_pkg.sv | 27 ++
 rtl/cic_dec_scale.sv | 62 ++++++
 rtl/cic_dec_strobed.sv | 148 ++++++++++++++
 tb/tb_cic_dec_strobed.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_dec_strobed_pkg.sv
// rtl/cic_dec_strobed_pkg.sv - shared constants and helpers for the strobed CIC decimator
// Purpose: default geometry of the decimator, the derived accumulator width and
// the ceil-log2 helper that selects the output shift from the decimation rate.
// Ports: none (package).
package cic_dec_strobed_pkg;

  localparam int WIDTH_DEF         = 18;
  localparam int N_STAGES_DEF      = 4;
  localparam int MAX_RATE_LOG2_DEF = 7;
  localparam int ACC_DEF           = WIDTH_DEF + N_STAGES_DEF * MAX_RATE_LOG2_DEF;

  // Integrator/comb width: enough headroom for the full R^N gain at the maximum rate.
  function automatic int acc_width(input int width, input int n_stages, input int max_rate_log2);
    return width + n_stages * max_rate_log2;
  endfunction

  // ceil(log2(r)) for r in 1..255; r = 0 and r = 1 both give 0.
  function automatic logic [3:0] clog2_rate(input logic [7:0] r);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if ((9'd1 << i) < {1'b0, r}) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/cic_dec_scale.sv
// rtl/cic_dec_scale.sv - variable shift, half-up rounding and saturation of the comb output
// Purpose: scales the full-width comb result down to the output sample width in
// one register stage; data is held between strobes.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clr               drops any strobe in flight (decimator stopped)
//   in_stb, in_data   comb output strobe and value (ACC bits, two's complement)
//   shift             right-shift amount, stable while the decimator runs
//   out_stb, out_data registered scaled result
module cic_dec_scale
  import cic_dec_strobed_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC   = ACC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_stb,
  input  logic [ACC-1:0]   in_data,
  input  logic [7:0]       shift,
  output logic             out_stb,
  output logic [WIDTH-1:0] out_data
);

  // One extra bit so adding the rounding constant can never overflow.
  localparam logic signed [ACC:0] MAXV = {{(ACC + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC:0] MINV = {{(ACC + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic signed [ACC:0] rnd;
  logic signed [ACC:0] sum;
  logic signed [ACC:0] shifted;
  logic [WIDTH-1:0]    sat;
  logic                stb_d, stb_q;
  logic [WIDTH-1:0]    data_d, data_q;

  always_comb begin
    rnd = '0;
    if (shift != 8'd0) rnd = {{ACC{1'b0}}, 1'b1} << (shift - 8'd1);
    sum     = $signed({in_data[ACC-1], in_data}) + rnd;
    shifted = sum >>> shift;
    if (shifted > MAXV)      sat = MAXV[WIDTH-1:0];
    else if (shifted < MINV) sat = MINV[WIDTH-1:0];
    else                     sat = shifted[WIDTH-1:0];
    stb_d  = in_stb & ~clr;
    data_d = (in_stb & ~clr) ? sat : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stb_q  <= 1'b0;
      data_q <= '0;
    end else begin
      stb_q  <= stb_d;
      data_q <= data_d;
    end
  end

  assign out_stb  = stb_q;
  assign out_data = data_q;

endmodule

// File: rtl/cic_dec_strobed.sv
// rtl/cic_dec_strobed.sv - strobed N-stage CIC decimator with bypass
// Purpose: pipelined integrator chain at the input strobe rate, decimation
// counter, comb chain at the output rate, scaling and a bypass-capable output register.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   run                  enable; low clears datapath and counter, captures rate
//   bypass               route strobe_in/data_in straight to the output register
//   rate                 decimation rate 1..128 (0 treated as 1)
//   strobe_in, data_in   input sample strobe and value
//   strobe_out, data_out decimated sample strobe and value (held between strobes)
module cic_dec_strobed
  import cic_dec_strobed_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int N_STAGES      = N_STAGES_DEF,
  parameter int MAX_RATE_LOG2 = MAX_RATE_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             bypass,
  input  logic [7:0]       rate,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             strobe_out,
  output logic [WIDTH-1:0] data_out
);

  localparam int ACC = acc_width(WIDTH, N_STAGES, MAX_RATE_LOG2);

  logic [N_STAGES-1:0][ACC-1:0] int_d, int_q;
  logic [N_STAGES:0][ACC-1:0]   c_d, c_q;
  logic [N_STAGES-1:0][ACC-1:0] dly_d, dly_q;
  logic [N_STAGES:0]            stb_d, stb_q;
  logic [7:0]                   cnt_d, cnt_q;
  logic [7:0]                   rate_d, rate_q;
  logic                         dec_stb_d, dec_stb_q;
  logic                         strobe_out_d, strobe_out_q;
  logic [WIDTH-1:0]             data_out_d, data_out_q;

  logic             accept;
  logic [7:0]       rate_eff;
  logic [7:0]       shift;
  logic [ACC-1:0]   data_ext;
  logic             sc_stb;
  logic [WIDTH-1:0] sc_data;

  assign accept   = strobe_in & run;
  assign rate_eff = (rate_q == 8'd0) ? 8'd1 : rate_q;
  assign shift    = 8'(N_STAGES * int'(clog2_rate(rate_eff)));
  assign data_ext = {{(ACC - WIDTH){data_in[WIDTH-1]}}, data_in};

  always_comb begin
    int_d     = int_q;
    c_d       = c_q;
    dly_d     = dly_q;
    stb_d     = '0;
    cnt_d     = cnt_q;
    dec_stb_d = 1'b0;
    rate_d    = run ? rate_q : rate;

    // Each integrator adds the previous stage's old value: a pipelined chain
    // that only advances on accepted input strobes.
    if (accept) begin
      int_d[0] = int_q[0] + data_ext;
      for (int k = 1; k < N_STAGES; k++) int_d[k] = int_q[k] + int_q[k-1];
      if (cnt_q == rate_eff - 8'd1) begin
        cnt_d     = '0;
        dec_stb_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // Comb input samples the last integrator one cycle after decimation, so it
    // already holds the decimating sample's update.
    stb_d[0] = dec_stb_q;
    if (dec_stb_q) c_d[0] = int_q[N_STAGES-1];

    for (int k = 1; k <= N_STAGES; k++) begin
      stb_d[k] = stb_q[k-1];
      if (stb_q[k-1]) begin
        c_d[k]     = c_q[k-1] - dly_q[k-1];
        dly_d[k-1] = c_q[k-1];
      end
    end

    if (!run) begin
      int_d     = '0;
      c_d       = '0;
      dly_d     = '0;
      stb_d     = '0;
      cnt_d     = '0;
      dec_stb_d = 1'b0;
    end
  end

  cic_dec_scale #(
    .WIDTH (WIDTH),
    .ACC   (ACC)
  ) u_scale (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (~run),
    .in_stb   (stb_q[N_STAGES]),
    .in_data  (c_q[N_STAGES]),
    .shift    (shift),
    .out_stb  (sc_stb),
    .out_data (sc_data)
  );

  // Output register: bypass mirrors the input; otherwise forward scaled
  // results only while running so a stop discards anything in flight.
  always_comb begin
    strobe_out_d = bypass ? strobe_in : (run & sc_stb);
    data_out_d   = data_out_q;
    if (bypass)             data_out_d = data_in;
    else if (run & sc_stb)  data_out_d = sc_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_q        <= '0;
      c_q          <= '0;
      dly_q        <= '0;
      stb_q        <= '0;
      cnt_q        <= '0;
      rate_q       <= '0;
      dec_stb_q    <= 1'b0;
      strobe_out_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      int_q        <= int_d;
      c_q          <= c_d;
      dly_q        <= dly_d;
      stb_q        <= stb_d;
      cnt_q        <= cnt_d;
      rate_q       <= rate_d;
      dec_stb_q    <= dec_stb_d;
      strobe_out_q <= strobe_out_d;
      data_out_q   <= data_out_d;
    end
  end

  assign strobe_out = strobe_out_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_cic_dec_strobed.sv
// tb/tb_cic_dec_strobed.sv - self-checking bench for the strobed CIC decimator
module tb_cic_dec_strobed;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst_n, run, bypass, strobe_in;
  logic [7:0]   rate;
  logic [W-1:0] data_in;
  logic         strobe_out;
  logic [W-1:0] data_out;

  always #5 clk = ~clk;

  cic_dec_strobed dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bypass     (bypass),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .data_in    (data_in),
    .strobe_out (strobe_out),
    .data_out   (data_out)
  );

  int checks = 0;
  int fails  = 0;
  int fail_lines = 0;

  // Behavioural model: y = input sequence convolved with N cascaded length-R
  // boxcars, delayed by N-1 samples (pipelined integrators), sampled every R-th
  // strobe, rounded, shifted and saturated.
  longint       hist[$];
  longint       h[];
  int           h_rate = 0;
  int           rate_m = 0;
  int           nstr   = 0;
  bit           pend_v[16];
  logic [W-1:0] pend_d[16];
  logic         exp_stb  = 1'b0;
  logic [W-1:0] exp_data = '0;
  int           cyc = 0;
  bit           model_live = 1'b0;

  function automatic void build_h(input int r);
    longint tmp[];
    h = new[1];
    h[0] = 1;
    for (int s = 0; s < 4; s++) begin
      tmp = new[h.size() + r - 1];
      foreach (tmp[i]) tmp[i] = 0;
      foreach (h[i]) for (int j = 0; j < r; j++) tmp[i + j] += h[i];
      h = tmp;
    end
    h_rate = r;
  endfunction

  function automatic logic [W-1:0] cic_value(input int r);
    longint y;
    longint v;
    int     base;
    int     s;
    y = 0;
    if (h_rate != r) build_h(r);
    base = hist.size() - 4;
    for (int i = 0; i < h.size(); i++) if (base - i >= 0) y += h[i] * hist[base - i];
    s = 4 * $clog2(r);
    v = (s > 0) ? ((y + (64'sd1 <<< (s - 1))) >>> s) : y;
    if (v > 131071)  v = 131071;
    if (v < -131072) v = -131072;
    return v[W-1:0];
  endfunction

  always @(posedge clk) begin
    int slot;
    int r;
    cyc++;
    model_live = 1'b1;
    slot = cyc % 16;
    if (!rst_n) begin
      hist.delete();
      nstr   = 0;
      rate_m = 0;
      foreach (pend_v[i]) pend_v[i] = 1'b0;
      exp_stb  = 1'b0;
      exp_data = '0;
    end else begin
      if (bypass) begin
        exp_stb  = strobe_in;
        exp_data = data_in;
      end else if (run && pend_v[slot]) begin
        exp_stb  = 1'b1;
        exp_data = pend_d[slot];
      end else begin
        exp_stb = 1'b0;
      end
      pend_v[slot] = 1'b0;
      if (!run) begin
        hist.delete();
        nstr = 0;
        foreach (pend_v[i]) pend_v[i] = 1'b0;
        rate_m = int'(rate);
      end else if (strobe_in) begin
        hist.push_back(longint'($signed(data_in)));
        nstr++;
        r = (rate_m == 0) ? 1 : rate_m;
        if (nstr % r == 0) begin
          pend_v[(cyc + 7) % 16] = 1'b1;
          pend_d[(cyc + 7) % 16] = cic_value(r);
        end
      end
    end
  end

  // Output observation: per-cycle model compare plus pulse statistics.
  int                  pulse_cnt = 0;
  logic signed [W-1:0] last_val  = '0;
  int                  last_cyc  = 0;
  longint              sum_nz    = 0;
  int                  cnt_nz    = 0;

  always begin
    @(posedge clk);
    #1;
    if (model_live) begin
      checks++;
      if (strobe_out !== exp_stb) begin
        fails++;
        if (fail_lines < 20) $display("FAIL model_strobe cyc %0d: got %b expected %b", cyc, strobe_out, exp_stb);
        fail_lines++;
      end
      checks++;
      if (data_out !== exp_data) begin
        fails++;
        if (fail_lines < 20) $display("FAIL model_data cyc %0d: got %0d expected %0d", cyc, $signed(data_out), $signed(exp_data));
        fail_lines++;
      end
    end
    if (strobe_out === 1'b1) begin
      pulse_cnt++;
      last_val = data_out;
      last_cyc = cyc;
      if (data_out != '0) begin
        sum_nz += longint'($signed(data_out));
        cnt_nz++;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [W-1:0] d);
    strobe_in = st;
    data_in   = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0);
  endtask

  task automatic set_rate(input int r);
    run  = 1'b0;
    rate = 8'(r);
    idle(2);
    run = 1'b1;
  endtask

  initial begin
    int ts;
    int nst;
    logic st;
    rst_n = 1'b0; run = 1'b0; bypass = 1'b0; rate = 8'd0; strobe_in = 1'b0; data_in = '0;
    @(negedge clk);
    idle(3);
    check("reset_strobe_out", longint'(strobe_out), 0);
    check("reset_data_out", longint'(data_out), 0);
    rst_n = 1'b1;

    // DC 1000 at rate 8
    set_rate(8);
    pulse_cnt = 0;
    repeat (80) drive(1'b1, 18'd1000);
    idle(10);
    check("dc_r8_value", longint'(last_val), 1000);
    check("dc_r8_count", pulse_cnt, 10);

    // DC 1000 at rate 5: gain (5/8)^4
    set_rate(5);
    pulse_cnt = 0;
    repeat (50) drive(1'b1, 18'd1000);
    idle(10);
    check("dc_r5_value", longint'(last_val), 153);
    check("dc_r5_count", pulse_cnt, 10);

    // Rate 1: random 50% duty, then a back-to-back burst
    set_rate(1);
    pulse_cnt = 0;
    nst = 0;
    repeat (20) begin
      st = 1'($urandom_range(0, 1));
      if (st) nst++;
      drive(st, W'($urandom));
    end
    repeat (10) drive(1'b1, W'($urandom));
    drive(1'b1, 18'd777);
    drive(1'b1, 18'd0);
    drive(1'b1, 18'd0);
    ts = cyc;
    drive(1'b1, 18'd0);
    idle(10);
    check("r1_delayed_sample", longint'(last_val), 777);
    check("r1_latency", last_cyc - ts, 8);
    check("r1_count", pulse_cnt, nst + 14);

    // Rate 128, full-scale negative DC: integrators wrap
    set_rate(128);
    pulse_cnt = 0;
    repeat (1536) drive(1'b1, 18'h20000);
    idle(10);
    check("dc_r128_value", longint'(last_val), -131072);
    check("dc_r128_count", pulse_cnt, 12);

    // Impulse at rate 4
    set_rate(4);
    sum_nz = 0;
    cnt_nz = 0;
    drive(1'b1, 18'd65536);
    repeat (39) drive(1'b1, 18'd0);
    idle(10);
    checks++;
    if (sum_nz < 16380 || sum_nz > 16388) begin
      fails++;
      $display("FAIL impulse_sum: got %0d expected 16384 +/-4", sum_nz);
    end
    checks++;
    if (cnt_nz > 4 || cnt_nz == 0) begin
      fails++;
      $display("FAIL impulse_nonzero_count: got %0d expected 1..4", cnt_nz);
    end

    // Reset mid-decimation (cnt = 3 at rate 8), then DC 500
    set_rate(8);
    repeat (3) drive(1'b1, 18'd700);
    pulse_cnt = 0;
    rst_n = 1'b0;
    drive(1'b1, 18'd700);
    rst_n = 1'b1;
    set_rate(8);
    repeat (7) drive(1'b1, 18'd500);
    idle(10);
    check("post_reset_7_strobes", pulse_cnt, 0);
    drive(1'b1, 18'd500);
    idle(10);
    check("post_reset_count", pulse_cnt, 1);
    check("post_reset_first_value", longint'(last_val), 9);

    // Bypass at rate 8, then back to decimation mid-stream
    set_rate(8);
    bypass = 1'b1;
    repeat (30) drive(1'($urandom_range(0, 1)), W'($urandom));
    ts = cyc;
    drive(1'b1, 18'd12345);
    check("bypass_strobe", longint'(strobe_out), 1);
    check("bypass_data", longint'(data_out), 12345);
    check("bypass_latency", last_cyc - ts, 1);
    bypass = 1'b0;
    repeat (40) drive(1'b1, 18'd2000);
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
